// File: rtl/mac_array_seq_ctrl.sv
// Sequencer that runs C = A x B on an elementwise MxM MAC array via M broadcast steps.
// Matrices are flattened row-major: element (i,j) sits at [(i*M+j)*W +: W].
module mac_array_seq_ctrl #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int M      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    accumulate,
  input  logic [M*M*DATA_W-1:0]   a_in,
  input  logic [M*M*DATA_W-1:0]   b_in,
  output logic                    busy,
  output logic                    mac_clr,
  output logic                    mac_en,
  output logic [M*M*DATA_W-1:0]   mac_a,
  output logic [M*M*DATA_W-1:0]   mac_b,
  input  logic [M*M*ACC_W-1:0]    mac_acc,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [M*M*ACC_W-1:0]    res_c
);

  localparam int OPW  = M * M * DATA_W;
  localparam int RESW = M * M * ACC_W;
  localparam int K_W  = (M > 1) ? $clog2(M) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(M - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t            state_q, state_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [OPW-1:0]    a_q, a_d, b_q, b_d;
  logic              mac_clr_q, mac_clr_d;
  logic              mac_en_q, mac_en_d;
  logic [OPW-1:0]    mac_a_q, mac_a_d, mac_b_q, mac_b_d;
  logic              res_valid_q, res_valid_d;
  logic [RESW-1:0]   res_c_q, res_c_d;

  logic              load_step;
  logic [K_W-1:0]    step_k;
  logic [OPW-1:0]    src_a, src_b;
  logic [OPW-1:0]    step_a, step_b;
  logic [DATA_W-1:0] src_a_e [M][M];
  logic [DATA_W-1:0] src_b_e [M][M];

  // Step-0 operands are loaded on the accept edge itself (no-clear path), so read the
  // live inputs while idle and the latched copies afterwards.
  assign src_a = (state_q == IDLE) ? a_in : a_q;
  assign src_b = (state_q == IDLE) ? b_in : b_q;

  for (genvar gi = 0; gi < M; gi++) begin : g_row
    for (genvar gj = 0; gj < M; gj++) begin : g_col
      assign src_a_e[gi][gj] = src_a[(gi*M+gj)*DATA_W +: DATA_W];
      assign src_b_e[gi][gj] = src_b[(gi*M+gj)*DATA_W +: DATA_W];
      assign step_a[(gi*M+gj)*DATA_W +: DATA_W] = src_a_e[gi][step_k];
      assign step_b[(gi*M+gj)*DATA_W +: DATA_W] = src_b_e[step_k][gj];
    end
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    mac_clr_d   = 1'b0;
    mac_en_d    = 1'b0;
    load_step   = 1'b0;
    step_k      = '0;
    res_valid_d = res_valid_q;
    res_c_d     = res_c_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d = a_in;
          b_d = b_in;
          k_d = '0;
          if (accumulate) begin
            state_d   = RUN;
            mac_en_d  = 1'b1;
            load_step = 1'b1;
          end else begin
            state_d   = CLEAR;
            mac_clr_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        state_d   = RUN;
        k_d       = '0;
        mac_en_d  = 1'b1;
        load_step = 1'b1;
      end
      RUN: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
          k_d     = '0;
        end else begin
          k_d       = k_q + 1'b1;
          step_k    = k_q + 1'b1;
          mac_en_d  = 1'b1;
          load_step = 1'b1;
        end
      end
      DRAIN: begin
        state_d     = DONE;
        res_c_d     = mac_acc;
        res_valid_d = 1'b1;
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mac_a_d = load_step ? step_a : '0;
    mac_b_d = load_step ? step_b : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      mac_clr_q   <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mac_clr_q   <= mac_clr_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      res_valid_q <= res_valid_d;
      res_c_q     <= res_c_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mac_clr   = mac_clr_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign res_valid = res_valid_q;
  assign res_c     = res_c_q;

endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// Scoreboard bench for mac_array_seq_ctrl with a behavioural MAC array and matrix-product model.
module tb_mac_array_seq_ctrl;
  localparam int M      = 4;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 32;
  localparam int OPW    = M * M * DATA_W;
  localparam int RESW   = M * M * ACC_W;

  logic            clk = 1'b0;
  logic            rst, start, accumulate, res_ready;
  logic [OPW-1:0]  a_in, b_in, mac_a, mac_b;
  logic            busy, mac_clr, mac_en, res_valid;
  logic [RESW-1:0] mac_acc, res_c;

  mac_array_seq_ctrl #(.DATA_W(DATA_W), .ACC_W(ACC_W), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .a_in(a_in), .b_in(b_in), .busy(busy), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc), .res_valid(res_valid),
    .res_ready(res_ready), .res_c(res_c)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cur_a [M][M];
  int cur_b [M][M];
  int ref_c [M][M];
  int arr   [M][M];
  int step_cnt = 0;
  int clr_cnt  = 0;
  logic [RESW-1:0] sb [$];

  // Elementwise MAC array: clear on mac_clr, accumulate a*b while enabled, not touched by rst.
  always @(posedge clk) begin
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        if (mac_clr) arr[i][j] <= 0;
        else if (mac_en)
          arr[i][j] <= arr[i][j] + int'($signed(mac_a[(i*M+j)*DATA_W +: DATA_W]))
                                 * int'($signed(mac_b[(i*M+j)*DATA_W +: DATA_W]));
  end

  always_comb begin
    mac_acc = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        mac_acc[(i*M+j)*ACC_W +: ACC_W] = arr[i][j];
  end

  task automatic chk(input string name, input logic [RESW-1:0] act, input logic [RESW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [OPW-1:0] bcast_a(input int k);
    logic [OPW-1:0] r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        r[(i*M+j)*DATA_W +: DATA_W] = DATA_W'(cur_a[i][k]);
    return r;
  endfunction

  function automatic logic [OPW-1:0] bcast_b(input int k);
    logic [OPW-1:0] r;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        r[(i*M+j)*DATA_W +: DATA_W] = DATA_W'(cur_b[k][j]);
    return r;
  endfunction

  // Monitor: broadcast pattern per enabled step, run length, clear pulses, result scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      step_cnt = 0;
    end else begin
      if (mac_clr) clr_cnt++;
      if (mac_en) begin
        if (step_cnt < M) begin
          chk("step_a", RESW'(mac_a), RESW'(bcast_a(step_cnt)));
          chk("step_b", RESW'(mac_b), RESW'(bcast_b(step_cnt)));
        end
        step_cnt++;
      end else if (step_cnt != 0) begin
        chk("run_len", RESW'(step_cnt), RESW'(M));
        step_cnt = 0;
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("FAIL unexpected_result: got %0h expected none", res_c);
        end else begin
          chk("res_c", res_c, sb.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctl"}, RESW'({busy, mac_clr, mac_en, res_valid}), '0);
    chk({name, "_mac_a"}, RESW'(mac_a), '0);
    chk({name, "_mac_b"}, RESW'(mac_b), '0);
    chk({name, "_res_c"}, res_c, '0);
  endtask

  task automatic pack_ops(output logic [OPW-1:0] pa, output logic [OPW-1:0] pb);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        pa[(i*M+j)*DATA_W +: DATA_W] = DATA_W'(cur_a[i][j]);
        pb[(i*M+j)*DATA_W +: DATA_W] = DATA_W'(cur_b[i][j]);
      end
  endtask

  task automatic run_op(input bit acc, input bit hold);
    logic [OPW-1:0]  pa, pb;
    logic [RESW-1:0] ev, held;
    int cyc, s;
    pack_ops(pa, pb);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        s = acc ? ref_c[i][j] : 0;
        for (int k = 0; k < M; k++) s += cur_a[i][k] * cur_b[k][j];
        ref_c[i][j] = s;
        ev[(i*M+j)*ACC_W +: ACC_W] = ACC_W'(s);
      end
    sb.push_back(ev);
    clr_cnt    = 0;
    a_in       = pa;
    b_in       = pb;
    accumulate = acc;
    res_ready  = !hold;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    accumulate = 1'($urandom());
    a_in       = {$urandom(), $urandom(), $urandom(), $urandom()};
    b_in       = {$urandom(), $urandom(), $urandom(), $urandom()};
    cyc = 1;
    while (!res_valid && cyc < 20) begin
      chk("busy_run", RESW'(busy), RESW'(1));
      start = (hold && cyc == 3);
      tick();
      cyc++;
    end
    start = 1'b0;
    chk("latency", RESW'(cyc), RESW'(acc ? 6 : 7));
    if (hold) begin
      held = res_c;
      for (int h = 0; h < 10; h++) begin
        start = h[0];
        tick();
        chk("hold_valid", RESW'(res_valid), RESW'(1));
        chk("hold_busy", RESW'(busy), RESW'(1));
        chk("hold_c", res_c, held);
      end
      start     = 1'b0;
      res_ready = 1'b1;
    end
    cyc = 0;
    while (res_valid && cyc < 5) begin
      tick();
      cyc++;
    end
    chk("release_valid", RESW'(res_valid), '0);
    chk("idle_busy", RESW'(busy), '0);
    chk("clr_pulses", RESW'(clr_cnt), RESW'(acc ? 0 : 1));
  endtask

  task automatic set_mats(input int sel, input int av, input int bv);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        case (sel)
          0: begin cur_a[i][j] = av; cur_b[i][j] = bv; end
          1: begin cur_a[i][j] = (i == j) ? 1 : 0; cur_b[i][j] = 4*i + j - 8; end
          2: begin cur_a[i][j] = (i == j) ? 1 : 0; cur_b[i][j] = bv; end
          3: begin cur_a[i][j] = j + 1; cur_b[i][j] = 1; end
          default: begin
            cur_a[i][j] = int'($urandom_range(0, 255)) - 128;
            cur_b[i][j] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; accumulate = 1'b0; res_ready = 1'b1;
    a_in = '0; b_in = '0;
    tick();
    tick();
    check_zero("reset");
    rst = 1'b0;
    tick();

    set_mats(0, 1, 1);       run_op(1'b0, 1'b0);
    set_mats(1, 0, 0);       run_op(1'b0, 1'b0);
    set_mats(0, -128, -128); run_op(1'b0, 1'b0);
    run_op(1'b1, 1'b0);
    set_mats(4, 0, 0);       run_op(1'b0, 1'b1);

    // Abort mid-run at step k=2, then restart cleanly.
    set_mats(4, 0, 0);
    pack_ops(a_in, b_in);
    accumulate = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check_zero("abort_now");
    @(negedge clk);
    check_zero("abort_next");
    tick();
    rst = 1'b0;
    tick();
    set_mats(2, 0, 3);       run_op(1'b0, 1'b0);
    set_mats(3, 0, 0);       run_op(1'b0, 1'b0);

    for (int n = 0; n < 8; n++) begin
      set_mats(4, 0, 0);
      run_op((n == 0) ? 1'b0 : 1'($urandom()), 1'($urandom_range(0, 3) == 0));
    end

    tick();
    chk("sb_empty", RESW'(sb.size()), '0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/mac_array_seq_ctrl.md
Name: mac_array_seq_ctrl

Overview:
- Sequencer that computes C = A x B (signed, MxM) on the existing elementwise MxM MAC array.
- Latches A and B on start. Clears the array accumulators. Drives M broadcast steps, where step k feeds a[i][j]=A[i][k] and b[i][j]=B[k][j].
- Captures the accumulators and presents C on a valid/ready result interface.
- Sits between the operand-load logic (AXI side) and the MAC array.

Parameters:
- DATA_W, 8, operand element width (signed)
- ACC_W, 32, accumulator/result element width (signed)
- M, 4, matrix dimension; also the number of accumulate steps

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request a multiply; accepted only in IDLE
- accumulate  input  1  sampled with start; 1 = skip the clear and add onto the existing accumulators (tiling)
- a_in  input  [M][M] x DATA_W signed  matrix A, sampled on the start-accept edge
- b_in  input  [M][M] x DATA_W signed  matrix B, sampled on the start-accept edge
- busy  output  1  high in every state except IDLE
- mac_clr  output  1  one-cycle accumulator clear request; integration maps it to the array reset
- mac_en  output  1  MAC array enable
- mac_a  output  [M][M] x DATA_W signed  array a operands
- mac_b  output  [M][M] x DATA_W signed  array b operands
- mac_acc  input  [M][M] x ACC_W signed  array accumulator outputs
- res_valid  output  1  result C valid
- res_ready  input  1  consumer accepts C
- res_c  output  [M][M] x ACC_W signed  registered result matrix

Behaviour:
- Reset (async, any state):
  - State goes to IDLE; k = 0.
  - busy, mac_clr, mac_en, res_valid = 0.
  - mac_a, mac_b, res_c and the latched A/B go to all zeros.
- The array accumulates on the clock edge while en=1; the new acc is visible the following cycle. mac_clr clears the accumulators by the next edge.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE:
  - On start=1, latch a_in, b_in and accumulate.
  - Next state is CLEAR if accumulate=0, else RUN.
  - start in any other state is ignored; there is no queuing.
- CLEAR (1 cycle): mac_clr=1, mac_en=0. Next state RUN, with k=0.
- RUN (M cycles, k = 0..M-1):
  - mac_en=1.
  - mac_a[i][j] = A[i][k] and mac_b[i][j] = B[k][j] for all i, j.
  - k increments each cycle. After k=M-1, go to DRAIN and reset k to 0.
- DRAIN (1 cycle):
  - mac_en=0.
  - On the exit edge, res_c <= mac_acc and res_valid <= 1.
  - Next state DONE.
- DONE:
  - res_valid=1; res_c is held stable.
  - When res_valid && res_ready, clear res_valid on that edge and go to IDLE.
- mac_a and mac_b are registered outputs, driven to zero outside RUN. mac_en is registered. Operand and enable timing must line up: the array sees step-k operands in the same cycle mac_en=1 for step k.
- Latency, start accepted at edge T0:
  - accumulate=0: CLEAR in T1, RUN T1+1..T1+M, DRAIN T1+M+1, res_valid high from T1+M+2 (cycle 7 for M=4).
  - accumulate=1: one cycle earlier (no CLEAR).
- busy deasserts on the same edge DONE exits to IDLE. start may be re-asserted the cycle after.
- Arithmetic: the controller does no arithmetic. Sign extension and overflow wrap are the array's responsibility; res_c is a bit-exact copy of mac_acc.
- Reset asserted mid-RUN or mid-DONE: everything aborts immediately and no partial result is presented. The array accumulators are not guaranteed clear, so the next non-accumulate start clears them.
- res_ready high outside DONE has no effect.

Test Plan:
- A = all 1, B = all 1, accumulate=0 -> every res_c element = 4 (M=4); res_valid first high at cycle 7 after start; busy high cycles 1..7.
- A = identity, B[i][j] = 4*i+j-8 -> res_c == B, including negative elements -8..-1.
- A = B = all -128 -> every res_c element = 65536. Then a second start with accumulate=1 and the same operands -> 131072; no mac_clr pulse seen on the second run.
- res_ready held low 10 cycles in DONE -> res_valid and res_c stable throughout. start pulses during RUN and DONE are ignored (exactly one result, busy never drops early).
- Assert rst during RUN at k=2 -> all outputs zero next cycle, state IDLE. A fresh start with A = identity, B = all 3 -> every res_c element = 3, with mac_clr seen.
- Per-step check with A[i][k] = k+1, B = all 1: mac_a/mac_b match the step-k broadcast pattern while mac_en=1 for exactly M consecutive cycles -> res_c[i][j] = 10.
